if_id_register: RTL and testbench
=================================

Name: if_id_register

Overview:
- Pipeline register between instruction fetch and decode in the 5-stage MIPS core.
- Captures PC, PC+4 and the fetched instruction each cycle.
- Supports hold (stall) and bubble insertion (flush).
- Tracks branch-delay-slot membership and flags instruction-fetch address errors (AdEL) for the exception logic downstream.

Parameters:
- RESET_PC, 32'h0000_3000, PC value presented on ID_PC after reset.
- TEXT_BASE, 32'h0000_3000, lowest legal fetch address.
- TEXT_END, 32'h0000_6FFC, highest legal fetch address (inclusive).
- EXC_ADEL, 5'd4, exception code reported for an illegal fetch address.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low; asserted when 0.
- IF_PC  input  32  PC of the instruction fetched this cycle.
- IF_PC4  input  32  IF_PC+4.
- IF_Inst  input  32  instruction word fetched this cycle.
- stall  input  1  hold all ID outputs (hazard unit).
- flush  input  1  replace ID contents with a bubble (exception/eret).
- ID_is_jump  input  1  instruction currently in ID is a branch/jump, so the next one captured is its delay slot.
- ID_PC  output  32  registered PC.
- ID_PC4  output  32  registered PC+4.
- ID_Inst  output  32  registered instruction; 0 (nop) for bubbles and faults.
- ID_valid  output  1  1 = real instruction; 0 = bubble.
- ID_in_delay_slot  output  1  registered instruction is a delay-slot instruction.
- ID_exc_code  output  5  0 = none; EXC_ADEL = fetch address error.

Behaviour:
- Reset (reset==0 at a rising edge):
  - ID_PC=RESET_PC, ID_PC4=RESET_PC+4, ID_Inst=0.
  - ID_valid=0, ID_in_delay_slot=0, ID_exc_code=0.
  - Reset overrides stall and flush.
- Priority at each edge: reset > flush > stall > load.
- Flush:
  - ID_Inst=0, ID_valid=0, ID_in_delay_slot=0, ID_exc_code=0.
  - ID_PC and ID_PC4 load IF_PC and IF_PC4 so the exception logic sees a sensible PC.
  - Flush applies even if stall is asserted in the same cycle.
- Stall (no flush): every output register holds its value. ID_is_jump is ignored.
- Load (neither stall nor flush):
  - ID_PC=IF_PC, ID_PC4=IF_PC4, ID_valid=1.
  - ID_in_delay_slot = ID_is_jump sampled in that same cycle, gated by ID_valid (a bubble never creates a delay slot).
- Fetch check, evaluated combinationally on IF_PC:
  - Fault when IF_PC[1:0]!=0, or IF_PC<TEXT_BASE, or IF_PC>TEXT_END (unsigned compare).
  - On a fault at load: ID_Inst=0, ID_exc_code=EXC_ADEL, ID_valid=1 (the faulting slot stays real so EPC is correct).
  - Without a fault: ID_Inst=IF_Inst, ID_exc_code=0.
- Two-state control FSM, next state decided by the edge-priority rules above:
  - RUN: loading. Transitions to HOLD on stall without flush.
  - HOLD: stalled. Transitions to RUN on the first cycle without stall, or on flush.
  - Only observable effect: in HOLD the delay-slot flag is frozen with the held instruction.
- Latency: exactly 1 cycle from IF inputs to ID outputs when not stalled.
- Reset deasserted mid-stall: the first post-reset edge behaves as a normal load or stall according to its inputs. No state is remembered from before reset.
- Outputs are pure flops. No combinational path from inputs to outputs.

Optional Feature:
- Macro IF_ID_PERF_CNT_EN.
- When defined, adds output ports:
  - stall_cnt (32): counts edges where stall==1, flush==0, reset==1.
  - bubble_cnt (32): counts edges where flush==1, reset==1.
- Both counters reset to 0, saturate at 32'hFFFF_FFFF and never wrap.
- When not defined: neither port nor counter logic exists. Core behaviour is identical either way.

Test Plan:
- Reset then load: hold reset=0 for 2 edges → ID_PC=32'h3000, ID_PC4=32'h3004, ID_Inst=0, ID_valid=0. Release reset, drive IF_PC=32'h3000, IF_Inst=32'h3C011234 → after 1 edge ID_Inst=32'h3C011234, ID_valid=1, ID_exc_code=0.
- Stall hold: load PC 32'h3004, then stall=1 for 3 edges while IF_PC changes to 32'h3008 → ID_PC stays 32'h3004 for all 3 cycles. Drop stall → next edge ID_PC=32'h3008.
- Flush beats stall: stall=1, flush=1, IF_PC=32'h4180 → ID_Inst=0, ID_valid=0, ID_PC=32'h4180, ID_in_delay_slot=0.
- Delay slot: ID holds a beq with ID_is_jump=1, IF_PC=32'h300C → after the edge ID_in_delay_slot=1. Following load with ID_is_jump=0 → 0. Repeat with stall held 2 cycles → flag stays with the held instruction.
- Fetch faults: IF_PC=32'h3002 → ID_exc_code=4, ID_Inst=0, ID_valid=1. IF_PC=32'h7000 → ID_exc_code=4. IF_PC=32'h6FFC → ID_exc_code=0.
- With IF_ID_PERF_CNT_EN: 5 stall edges and 2 flush edges → stall_cnt=5, bubble_cnt=2. Preload a counter to 32'hFFFF_FFFF via a bench force → it stays 32'hFFFF_FFFF after a further stall.

Source files
------------

// File: rtl/if_id_register_if.sv
// rtl/if_id_register_if.sv - IF/ID pipeline register bus: fetch-side inputs, hazard controls, decode-side outputs
interface if_id_register_if;
  logic [31:0] IF_PC;
  logic [31:0] IF_PC4;
  logic [31:0] IF_Inst;
  logic        stall;
  logic        flush;
  logic        ID_is_jump;
  logic [31:0] ID_PC;
  logic [31:0] ID_PC4;
  logic [31:0] ID_Inst;
  logic        ID_valid;
  logic        ID_in_delay_slot;
  logic [4:0]  ID_exc_code;

  modport master (
    output IF_PC, IF_PC4, IF_Inst, stall, flush, ID_is_jump,
    input  ID_PC, ID_PC4, ID_Inst, ID_valid, ID_in_delay_slot, ID_exc_code
  );

  modport slave (
    input  IF_PC, IF_PC4, IF_Inst, stall, flush, ID_is_jump,
    output ID_PC, ID_PC4, ID_Inst, ID_valid, ID_in_delay_slot, ID_exc_code
  );
endinterface

// File: rtl/if_id_register.sv
// rtl/if_id_register.sv - IF/ID pipeline register with stall, flush, delay-slot tracking and AdEL fetch check
// Optional stall/bubble performance counters enabled by defining IF_ID_PERF_CNT_EN.
module if_id_register #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
  parameter logic [31:0] TEXT_END  = 32'h0000_6FFC,
  parameter logic [4:0]  EXC_ADEL  = 5'd4
) (
  input  logic               clk,
  input  logic               reset,
  if_id_register_if.slave    bus
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        bubble_cnt
`endif
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t      state;
  logic [31:0] pc_r;
  logic [31:0] pc4_r;
  logic [31:0] inst_r;
  logic        valid_r;
  logic        ds_r;
  logic [4:0]  exc_r;
  logic        fetch_fault;

  assign fetch_fault = (bus.IF_PC[1:0] != 2'b00) || (bus.IF_PC < TEXT_BASE) || (bus.IF_PC > TEXT_END);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= RUN;
      pc_r    <= RESET_PC;
      pc4_r   <= RESET_PC + 32'd4;
      inst_r  <= 32'd0;
      valid_r <= 1'b0;
      ds_r    <= 1'b0;
      exc_r   <= 5'd0;
    end else if (bus.flush) begin
      // PC still loads so EPC logic sees the address being squashed
      state   <= RUN;
      pc_r    <= bus.IF_PC;
      pc4_r   <= bus.IF_PC4;
      inst_r  <= 32'd0;
      valid_r <= 1'b0;
      ds_r    <= 1'b0;
      exc_r   <= 5'd0;
    end else begin
      case (state)
        RUN:     state <= bus.stall ? HOLD : RUN;
        HOLD:    state <= bus.stall ? HOLD : RUN;
        default: state <= RUN;
      endcase
      if (!bus.stall) begin
        pc_r    <= bus.IF_PC;
        pc4_r   <= bus.IF_PC4;
        valid_r <= 1'b1;
        // a bubble in ID cannot own a delay slot
        ds_r    <= bus.ID_is_jump & valid_r;
        inst_r  <= fetch_fault ? 32'd0 : bus.IF_Inst;
        exc_r   <= fetch_fault ? EXC_ADEL : 5'd0;
      end
    end
  end

  assign bus.ID_PC            = pc_r;
  assign bus.ID_PC4           = pc4_r;
  assign bus.ID_Inst          = inst_r;
  assign bus.ID_valid         = valid_r;
  assign bus.ID_in_delay_slot = ds_r;
  assign bus.ID_exc_code      = exc_r;

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] bubble_cnt_r;

  // saturating: a pinned counter signals overflow rather than wrapping
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_r  <= 32'd0;
      bubble_cnt_r <= 32'd0;
    end else begin
      if (bus.stall && !bus.flush && stall_cnt_r != 32'hFFFF_FFFF)
        stall_cnt_r <= stall_cnt_r + 32'd1;
      if (bus.flush && bubble_cnt_r != 32'hFFFF_FFFF)
        bubble_cnt_r <= bubble_cnt_r + 32'd1;
    end
  end

  assign stall_cnt  = stall_cnt_r;
  assign bubble_cnt = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_if_id_register.sv
// tb/tb_if_id_register.sv - scoreboard bench for if_id_register: directed test-plan cases plus random traffic
module tb_if_id_register;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] TEXT_BASE = 32'h0000_3000;
  localparam logic [31:0] TEXT_END  = 32'h0000_6FFC;
  localparam logic [4:0]  EXC_ADEL  = 5'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        valid;
    logic        ds;
    logic [4:0]  exc;
  } id_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  if_id_register_if bus();
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
`endif

  if_id_register dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  id_t model;
  id_t exp_q[$];
  int  checks = 0;
  int  passed = 0;

  initial begin
    bus.IF_PC = 32'h3000; bus.IF_PC4 = 32'h3004; bus.IF_Inst = 32'd0;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.ID_is_jump = 1'b0;
    model = '0;
  end

  // Reference: ID contents as a function of the previous ID contents and this cycle's inputs.
  task automatic step(input logic rst, input logic st, input logic fl, input logic jmp,
                      input logic [31:0] pc, input logic [31:0] inst);
    logic bad;
    @(negedge clk);
    reset = rst; bus.stall = st; bus.flush = fl; bus.ID_is_jump = jmp;
    bus.IF_PC = pc; bus.IF_PC4 = pc + 32'd4; bus.IF_Inst = inst;
    bad = (pc % 4 != 0) || (pc < TEXT_BASE) || (pc > TEXT_END);
    if (!rst)
      model = '{pc: RESET_PC, pc4: RESET_PC + 32'd4, inst: 32'd0, valid: 1'b0, ds: 1'b0, exc: 5'd0};
    else if (fl)
      model = '{pc: pc, pc4: pc + 32'd4, inst: 32'd0, valid: 1'b0, ds: 1'b0, exc: 5'd0};
    else if (!st) begin
      model.ds    = jmp && model.valid;
      model.valid = 1'b1;
      model.pc    = pc;
      model.pc4   = pc + 32'd4;
      model.inst  = bad ? 32'd0 : inst;
      model.exc   = bad ? EXC_ADEL : 5'd0;
    end
    exp_q.push_back(model);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s got=%h want=%h", name, got, want);
  endtask

  initial begin : monitor
    id_t e;
    id_t g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = '{pc: bus.ID_PC, pc4: bus.ID_PC4, inst: bus.ID_Inst, valid: bus.ID_valid,
              ds: bus.ID_in_delay_slot, exc: bus.ID_exc_code};
        checks++;
        if (g === e) passed++;
        else $display("FAIL id_regs got pc=%h pc4=%h inst=%h v=%b ds=%b exc=%0d want pc=%h pc4=%h inst=%h v=%b ds=%b exc=%0d",
                      g.pc, g.pc4, g.inst, g.valid, g.ds, g.exc, e.pc, e.pc4, e.inst, e.valid, e.ds, e.exc);
      end
    end
  end

  initial begin : stim
    logic [31:0] pc;
    // reset then load
    step(0, 0, 0, 0, 32'h3000, 32'h0);
    step(0, 1, 1, 0, 32'h3000, 32'h0);
    settle();
    check_lit("reset_pc", bus.ID_PC, 32'h3000);
    check_lit("reset_pc4", bus.ID_PC4, 32'h3004);
    check_lit("reset_inst", bus.ID_Inst, 32'h0);
    check_lit("reset_valid", {31'd0, bus.ID_valid}, 32'd0);
    step(1, 0, 0, 0, 32'h3000, 32'h3C011234);
    settle();
    check_lit("load_inst", bus.ID_Inst, 32'h3C011234);
    check_lit("load_valid", {31'd0, bus.ID_valid}, 32'd1);
    check_lit("load_exc", {27'd0, bus.ID_exc_code}, 32'd0);
    // stall hold
    step(1, 0, 0, 0, 32'h3004, 32'h1111_0000);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 32'h3008, 32'h2222_0000);
    settle();
    check_lit("stall_hold_pc", bus.ID_PC, 32'h3004);
    step(1, 0, 0, 0, 32'h3008, 32'h2222_0000);
    settle();
    check_lit("stall_release_pc", bus.ID_PC, 32'h3008);
    // flush beats stall
    step(1, 1, 1, 1, 32'h4180, 32'hDEAD_BEEF);
    settle();
    check_lit("flush_inst", bus.ID_Inst, 32'h0);
    check_lit("flush_valid", {31'd0, bus.ID_valid}, 32'd0);
    check_lit("flush_pc", bus.ID_PC, 32'h4180);
    check_lit("flush_ds", {31'd0, bus.ID_in_delay_slot}, 32'd0);
    // delay slot
    step(1, 0, 0, 0, 32'h3008, 32'h1000_0002);
    step(1, 0, 0, 1, 32'h300C, 32'h0000_0000);
    settle();
    check_lit("ds_set", {31'd0, bus.ID_in_delay_slot}, 32'd1);
    step(1, 0, 0, 0, 32'h3010, 32'h0);
    settle();
    check_lit("ds_clear", {31'd0, bus.ID_in_delay_slot}, 32'd0);
    step(1, 0, 0, 1, 32'h3014, 32'h0);
    step(1, 1, 0, 0, 32'h3018, 32'h0);
    step(1, 1, 0, 0, 32'h3018, 32'h0);
    settle();
    check_lit("ds_held", {31'd0, bus.ID_in_delay_slot}, 32'd1);
    // fetch faults
    step(1, 0, 0, 0, 32'h3002, 32'hABCD_0001);
    settle();
    check_lit("misaligned_exc", {27'd0, bus.ID_exc_code}, 32'd4);
    check_lit("misaligned_inst", bus.ID_Inst, 32'h0);
    check_lit("misaligned_valid", {31'd0, bus.ID_valid}, 32'd1);
    step(1, 0, 0, 0, 32'h7000, 32'hABCD_0002);
    settle();
    check_lit("above_end_exc", {27'd0, bus.ID_exc_code}, 32'd4);
    step(1, 0, 0, 0, 32'h6FFC, 32'hABCD_0003);
    settle();
    check_lit("at_end_exc", {27'd0, bus.ID_exc_code}, 32'd0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0: pc = $urandom;
        1: case ($urandom_range(0, 4))
             0: pc = 32'h2FFC;
             1: pc = 32'h3000;
             2: pc = 32'h6FFC;
             3: pc = 32'h7000;
             default: pc = 32'h3000 + 32'($urandom_range(1, 3));
           endcase
        default: pc = TEXT_BASE + 32'(4 * $urandom_range(0, 4095));
      endcase
      step(($urandom_range(0, 99) >= 3), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) < 3), pc, $urandom);
    end
`ifdef IF_ID_PERF_CNT_EN
    step(0, 0, 0, 0, 32'h3000, 32'h0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 32'h3000, 32'h0);
    for (int i = 0; i < 2; i++) step(1, 1, 1, 0, 32'h3000, 32'h0);
    settle();
    check_lit("stall_cnt", stall_cnt, 32'd5);
    check_lit("bubble_cnt", bubble_cnt, 32'd2);
    @(negedge clk);
    force dut.stall_cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_r;
    step(1, 1, 0, 0, 32'h3000, 32'h0);
    settle();
    check_lit("stall_cnt_sat", stall_cnt, 32'hFFFF_FFFF);
`endif
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
